udp_line_scheduler: RTL and testbench

// Sequences the UDP line-transmit path: arbitrates round-robin between the two camera line

---
 rtl/udp_line_scheduler.sv | 139 +++++++++++++
 tb/tb_udp_line_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_line_scheduler.sv
// rtl/udp_line_scheduler.sv - round-robin UDP line transmit scheduler
// Grants one camera line at a time, triggers udp_packet, counts payload bytes, then holds an inter-packet gap.
module udp_line_scheduler #(
  parameter int LINE_BYTES = 1280,
  parameter int ROW_W      = 11,
  parameter int GAP_CYC    = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       req,
  input  logic [ROW_W-1:0] row0,
  input  logic [ROW_W-1:0] row1,
  input  logic             tx_read_en,
  output logic [1:0]       grant,
  output logic             trig,
  output logic [15:0]      index,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(LINE_BYTES + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(LINE_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_TRIG,
    S_XFER,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [3:0]       seq_q, seq_d;
  logic [15:0]      index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      seq_q   <= 4'd0;
      index_q <= 16'd0;
      cnt_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    seq_d   = seq_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    grant   = 2'b00;
    trig    = 1'b0;

    // A byte strobe while no packet is in flight means udp_packet and the scheduler disagree.
    if (tx_read_en && (state_q != S_XFER)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (en && (|req)) begin
          sel_d   = (req == 2'b11) ? ~last_q : req[1];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        grant   = sel_q ? 2'b10 : 2'b01;
        index_d = {sel_q, seq_q, (sel_q ? row1 : row0)};
        last_d  = sel_q;
        seq_d   = seq_q + 4'd1;
        state_d = S_TRIG;
      end
      S_TRIG: begin
        trig    = 1'b1;
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tx_read_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (tx_read_en && (cnt_q == LAST_BYTE)) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_d == TMO_LIMIT) begin
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign index = index_q;
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_udp_line_scheduler.sv
// tb/tb_udp_line_scheduler.sv - directed self-checking bench for udp_line_scheduler
module tb_udp_line_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [10:0] row0 = 11'd0;
  logic [10:0] row1 = 11'd0;
  logic        tx_read_en = 1'b0;
  logic [1:0]  grant;
  logic        trig;
  logic [15:0] index;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  udp_line_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .row0      (row0),
    .row1      (row1),
    .tx_read_en(tx_read_en),
    .grant     (grant),
    .trig      (trig),
    .index     (index),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_read_en = 1'b0;
    #2;
    check("rst_outputs", {grant, trig, index, busy, err}, 21'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp_g);
    int n = 0;
    while (grant == 2'b00 && n < 300) begin
      tick();
      n++;
    end
    check(tag, grant, exp_g);
  endtask

  // Entered at posedge+1 with the FSM in GRANT; leaves it at posedge+1 in the first GAP cycle.
  task automatic run_packet(input string tag, input logic [15:0] exp_idx);
    tick();
    check({tag, "_trig"}, {trig, grant}, 3'b100);
    check({tag, "_index"}, index, exp_idx);
    tick();
    tx_read_en = 1'b1;
    repeat (1280) tick();
    tx_read_en = 1'b0;
  endtask

  initial begin
    logic [1:0] gacc;
    logic [15:0] exp_idx;
    int n;

    // Test 1: single cam1 line.
    do_reset();
    en = 1'b1;
    row0 = 11'd5;
    req = 2'b01;
    tick();
    check("t1_grant_latency", grant, 2'b01);
    req = 2'b00;
    run_packet("t1", 16'h0005);
    check("t1_gap_busy", busy, 1'b1);
    repeat (63) tick();
    check("t1_gap_end_busy", busy, 1'b1);
    tick();
    check("t1_idle_busy", busy, 1'b0);
    check("t1_no_err", err, 1'b0);

    // Test 2: round-robin with both requests held.
    do_reset();
    row0 = 11'd5;
    row1 = 11'd9;
    req = 2'b11;
    wait_grant("t2_g0", 2'b01);
    run_packet("t2_p0", 16'h0005);
    wait_grant("t2_g1", 2'b10);
    run_packet("t2_p1", 16'h8809);
    wait_grant("t2_g2", 2'b01);
    run_packet("t2_p2", 16'h1005);
    wait_grant("t2_g3", 2'b10);
    run_packet("t2_p3", 16'h9809);
    req = 2'b00;

    // Test 3: seq wraps after 16 packets from cam2.
    do_reset();
    row1 = 11'd719;
    req = 2'b10;
    for (int p = 0; p < 17; p++) begin
      exp_idx = {1'b1, 4'(p), 11'd719};
      wait_grant($sformatf("t3_g%0d", p), 2'b10);
      run_packet($sformatf("t3_p%0d", p), exp_idx);
    end

    // Test 4: stalled transfer times out, scheduler recovers, err stays set.
    row0 = 11'd3;
    req = 2'b01;
    wait_grant("t4_grant", 2'b01);
    tick();
    check("t4_index", index, 16'h0803);
    tick();
    tx_read_en = 1'b1;
    repeat (100) tick();
    tx_read_en = 1'b0;
    check("t4_err_before", err, 1'b0);
    n = 0;
    while (err == 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    check("t4_err_set", err, 1'b1);
    check("t4_timeout_window", (n >= 3900 && n <= 4000), 1'b1);
    check("t4_in_gap", busy, 1'b1);
    wait_grant("t4_regrant", 2'b01);
    run_packet("t4_p1", 16'h1003);
    req = 2'b00;
    check("t4_err_sticky", err, 1'b1);

    // Test 5: en drops mid-packet.
    do_reset();
    row0 = 11'd7;
    req = 2'b01;
    wait_grant("t5_grant", 2'b01);
    tick();
    check("t5_index", index, 16'h0007);
    tick();
    tx_read_en = 1'b1;
    repeat (600) tick();
    en = 1'b0;
    repeat (680) tick();
    tx_read_en = 1'b0;
    gacc = 2'b00;
    repeat (300) begin
      tick();
      gacc = gacc | grant;
    end
    check("t5_no_grant_en_low", gacc, 2'b00);
    check("t5_idle", busy, 1'b0);
    check("t5_no_err", err, 1'b0);
    en = 1'b1;
    tick();
    check("t5_grant_on_en", grant, 2'b01);
    tick();
    check("t5_index2", index, 16'h0807);

    // Test 6: asynchronous reset mid-XFER, then a stray strobe in IDLE.
    tick();
    tx_read_en = 1'b1;
    repeat (10) tick();
    #2;
    tx_read_en = 1'b0;
    en = 1'b0;
    req = 2'b00;
    rst = 1'b1;
    #1;
    check("t6_async_rst", {grant, trig, index, busy, err}, 21'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tx_read_en = 1'b1;
    tick();
    tx_read_en = 1'b0;
    check("t6_stray_err", err, 1'b1);
    gacc = 2'b00;
    repeat (10) begin
      gacc = gacc | {trig, busy};
      tick();
    end
    check("t6_no_trig", gacc, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
